// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Register file with per-register busy (scoreboard) bits.
//               Combinational read ports with write-through bypass; busy bits
//               are set by alloc, cleared by write-back, cleared en masse by
//               flush. Register 0 is hard-wired to zero and never busy.
// Ports       : sys_clk    - rising-edge clock
//               sys_rst_n  - asynchronous active-low reset
//               raddr      - packed read addresses, port k at [k*AW +: AW]
//               rdata      - packed read data, port k at [k*XLEN +: XLEN]
//               rbusy      - per-port busy flag of the addressed register
//               wen/waddr/wdata       - write-back port
//               alloc_en/alloc_addr   - destination reservation
//               flush      - drop all reservations
//               busy_any   - OR of all stored busy bits
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int  XLEN    = 32,
    parameter int  REG_NUM = 32,
    parameter int  RPORTS  = 2,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [RPORTS*AW-1:0]   raddr,
    output logic [RPORTS*XLEN-1:0] rdata,
    output logic [RPORTS-1:0]      rbusy,
    input  logic                   wen,
    input  logic [AW-1:0]          waddr,
    input  logic [XLEN-1:0]        wdata,
    input  logic                   alloc_en,
    input  logic [AW-1:0]          alloc_addr,
    input  logic                   flush,
    output logic                   busy_any
);

    logic [XLEN-1:0]    r_regs [REG_NUM];
    logic [REG_NUM-1:0] r_busy;
    logic [REG_NUM-1:0] w_busy_nxt;
    logic               w_wr_ok;
    logic               w_alloc_ok;

    assign w_wr_ok    = wen && (waddr != '0);
    assign w_alloc_ok = alloc_en && (alloc_addr != '0);

    // Order of the assignments encodes priority: alloc beats a same-address
    // write-back, and flush beats everything.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[waddr] = 1'b0;
        end
        if (w_alloc_ok) begin
            w_busy_nxt[alloc_addr] = 1'b1;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_busy <= w_busy_nxt;
            if (w_wr_ok) begin
                r_regs[waddr] <= wdata;
            end
        end
    end

    // Stored state only; a same-cycle write-back does not mask this flag.
    assign busy_any = |r_busy;

    generate
        for (genvar k = 0; k < RPORTS; k++) begin : g_rport
            logic [AW-1:0] w_ra;
            logic          w_zero;
            logic          w_hit;

            assign w_ra   = raddr[k*AW +: AW];
            assign w_zero = (w_ra == '0);
            // Bypass hit: the write-back data is being produced this cycle, so
            // the consumer can take it now and need not see the register busy.
            assign w_hit  = wen && !w_zero && (waddr == w_ra);

            assign rdata[k*XLEN +: XLEN] = w_zero ? '0 :
                                           w_hit  ? wdata : r_regs[w_ra];
            assign rbusy[k] = r_busy[w_ra] && !w_hit && !w_zero;
        end
    endgenerate

endmodule
`default_nettype wire
